filtro_mac: RTL and testbench

Time-multiplexed FIR band filter for the equalizer datapath. It sits directly upstream of the saturating band adder. Each sample strobe starts a sequential multiply-accumulate over a programmable coefficient set. One band output is produced per input sample, with a one-cycle valid pulse, and that output feeds the adder.

---
 rtl/filtro_mac.sv | 101 ++++++++++
 tb/tb_filtro_mac.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/filtro_mac.sv
// filtro_mac: time-multiplexed FIR band filter, one saturating multiply-accumulate tap per cycle.
// One band output per accepted sample, announced by a one-cycle listo pulse.
module filtro_mac #(
    parameter int ancho    = 20,
    parameter int fraccion = 11,
    parameter int taps     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     muestra_lista,
    input  logic [ancho-1:0]         X,
    input  logic                     coef_we,
    input  logic [$clog2(taps)-1:0]  coef_dir,
    input  logic [ancho-1:0]         coef_dato,
    output logic [ancho-1:0]         Y,
    output logic                     listo,
    output logic                     ocupado
);
    localparam int kw = $clog2(taps);
    localparam int pw = 2 * ancho;
    localparam logic [ancho-1:0] vmax = {1'b0, {(ancho-1){1'b1}}};
    localparam logic [ancho-1:0] vmin = {1'b1, {(ancho-1){1'b0}}};

    typedef enum logic {REPOSO, MAC} estado_t;

    estado_t estado_q, estado_d;
    logic [ancho-1:0] x_q [taps];
    logic [ancho-1:0] x_d [taps];
    logic [ancho-1:0] c_q [taps];
    logic [ancho-1:0] c_d [taps];
    logic [ancho-1:0] acc_q, acc_d, y_q, y_d;
    logic [kw-1:0]    k_q, k_d;
    logic             listo_q, listo_d;
    logic             inicio, fin, escribe;
    logic signed [pw-1:0] prod, desp;
    logic [ancho-1:0] s, suma, acc_n;

    always_comb begin
        inicio  = (estado_q == REPOSO) && muestra_lista;
        fin     = (estado_q == MAC) && (k_q == kw'(taps - 1));
        escribe = (estado_q == REPOSO) && coef_we && (int'(coef_dir) < taps);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado_q <= REPOSO;
        else        estado_q <= estado_d;
    end

    always_comb begin
        estado_d = inicio ? MAC : fin ? REPOSO : estado_q;
    end

    always_comb begin
        ocupado = (estado_q == MAC);
        listo   = listo_q;
        Y       = y_q;
    end

    // Product cannot overflow 2*ancho bits; only the scaled tap term needs clamping.
    always_comb begin
        prod  = pw'($signed(c_q[k_q])) * pw'($signed(x_q[k_q]));
        desp  = prod >>> fraccion;
        s     = (desp > $signed({{ancho{1'b0}}, vmax})) ? vmax :
                (desp < $signed({{ancho{1'b1}}, vmin})) ? vmin : desp[ancho-1:0];
        suma  = acc_q + s;
        acc_n = (!acc_q[ancho-1] && !s[ancho-1] &&  suma[ancho-1]) ? vmax :
                ( acc_q[ancho-1] &&  s[ancho-1] && !suma[ancho-1]) ? vmin : suma;
    end

    always_comb begin
        x_d = x_q;
        c_d = c_q;
        if (inicio) begin
            x_d[0] = X;
            for (int i = 1; i < taps; i++) x_d[i] = x_q[i-1];
        end
        if (escribe) c_d[coef_dir] = coef_dato;
        acc_d   = inicio ? '0 : (ocupado && !fin) ? acc_n : acc_q;
        k_d     = inicio ? '0 : (ocupado && !fin) ? k_q + kw'(1) : k_q;
        y_d     = fin ? acc_n : y_q;
        listo_d = fin;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= '{default: '0};
            c_q     <= '{default: '0};
            acc_q   <= '0;
            k_q     <= '0;
            y_q     <= '0;
            listo_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            y_q     <= y_d;
            listo_q <= listo_d;
        end
    end
endmodule

// File: tb/tb_filtro_mac.sv
// tb_filtro_mac: directed vectors with hand-computed outputs for filtro_mac.
module tb_filtro_mac;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic muestra_lista = 1'b0;
    logic coef_we = 1'b0;
    logic signed [19:0] X = '0;
    logic signed [19:0] coef_dato = '0;
    logic [2:0] coef_dir = '0;
    logic signed [19:0] Y;
    logic listo, ocupado;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    filtro_mac dut (
        .clk(clk), .reset(reset), .muestra_lista(muestra_lista), .X(X),
        .coef_we(coef_we), .coef_dir(coef_dir), .coef_dato(coef_dato),
        .Y(Y), .listo(listo), .ocupado(ocupado)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    task automatic espera_listo(input string tag, input int exp, input int lat, input bit cola);
        int n = 0;
        while (!listo && n < 20) begin
            paso();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk(tag, Y, exp);
        if (cola) begin
            paso();
            chk({tag, "_pulso"}, listo, 0);
        end
    endtask

    task automatic muestra(input string tag, input int v, input int exp);
        X = v;
        muestra_lista = 1'b1;
        paso();
        muestra_lista = 1'b0;
        coef_we = 1'b0;
        chk({tag, "_ocup"}, ocupado, 1);
        espera_listo(tag, exp, 5, 1);
    endtask

    task automatic escribe(input int d, input int v);
        coef_we = 1'b1;
        coef_dir = 3'(d);
        coef_dato = 20'(v);
        paso();
        coef_we = 1'b0;
    endtask

    task automatic rst();
        reset = 1'b0;
        paso();
        reset = 1'b1;
    endtask

    initial begin
        bit visto;
        paso();
        chk("rst_y", Y, 0);
        chk("rst_listo", listo, 0);
        chk("rst_ocup", ocupado, 0);
        reset = 1'b1;

        escribe(0, 2048); escribe(1, 1024); escribe(2, 512); escribe(3, 256); escribe(4, 128);
        muestra("imp0", 1000, 1000);
        muestra("imp1", 0, 500);
        muestra("imp2", 0, 250);
        muestra("imp3", 0, 125);
        muestra("imp4", 0, 62);

        rst();
        for (int i = 0; i < 5; i++) escribe(i, 2048);
        muestra("satp0", 400000, 400000);
        muestra("satp1", 400000, 524287);
        rst();
        for (int i = 0; i < 5; i++) escribe(i, 2048);
        muestra("satn0", -400000, -400000);
        muestra("satn1", -400000, -524288);

        rst();
        escribe(0, -524288);
        muestra("clamp", -524288, 524287);
        escribe(0, 1024);
        muestra("trunc", -3, -2);

        rst();
        escribe(1, 2048);
        X = 111; muestra_lista = 1'b1; paso(); muestra_lista = 1'b0;
        paso();
        X = 222; muestra_lista = 1'b1; paso(); muestra_lista = 1'b0;
        espera_listo("busy_a", 0, 3, 1);
        muestra("busy_b", 333, 111);
        X = 444; muestra_lista = 1'b1; paso(); muestra_lista = 1'b0;
        espera_listo("lc_a", 333, 5, 0);
        X = 555; muestra_lista = 1'b1; paso(); muestra_lista = 1'b0;
        chk("lc_ocup", ocupado, 1);
        chk("lc_listo", listo, 0);
        espera_listo("lc_b", 444, 5, 1);

        X = 600; muestra_lista = 1'b1; paso(); muestra_lista = 1'b0;
        coef_we = 1'b1; coef_dir = 3'd1; coef_dato = '0; paso(); coef_we = 1'b0;
        espera_listo("cw_a", 555, 4, 1);
        muestra("cw_b", 700, 600);
        escribe(7, 2048);
        muestra("dir7", 800, 700);
        coef_we = 1'b1; coef_dir = 3'd0; coef_dato = 20'sd2048;
        muestra("wr_str", 900, 1700);

        X = 1; muestra_lista = 1'b1; paso(); muestra_lista = 1'b0;
        paso(); paso();
        #3 reset = 1'b0;
        #1;
        chk("amid_y", Y, 0);
        chk("amid_listo", listo, 0);
        chk("amid_ocup", ocupado, 0);
        paso();
        reset = 1'b1;
        visto = 1'b0;
        for (int i = 0; i < 10; i++) begin
            paso();
            visto |= listo;
        end
        chk("amid_sin_listo", visto, 0);
        chk("amid_y_fin", Y, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
